// File: rtl/vis_pkg.sv
// Shared types and helpers for the bar-graph visualizer: pixel colour struct,
// fixed colours and the magnitude-to-height scaling.
package vis_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BLACK   = 24'h000000;
  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t BG      = 24'h000020;
  localparam rgb_t BAR_TOP = 24'hFFFF00;
  localparam rgb_t BAR_LOW = 24'h00FF00;

  localparam int MAX_MAG_W = 16;

  // h = (m * v_res) >> mag_w; the product is wide enough for any MAG_W up to MAX_MAG_W
  function automatic logic [9:0] bar_height(input logic [MAX_MAG_W-1:0] m,
                                            input int mag_w,
                                            input logic [9:0] v_res);
    logic [MAX_MAG_W+9:0] prod;
    prod = {10'd0, m} * {{MAX_MAG_W{1'b0}}, v_res};
    return 10'(prod >> mag_w);
  endfunction

endpackage

// File: rtl/vga_bar_renderer_if.sv
// Magnitude write port: valid/ready handshake carrying a channel and a magnitude.
interface vga_bar_renderer_if #(
  parameter int NUM_BARS = 16,
  parameter int MAG_W    = 8
);
  // one spare channel bit so out-of-range channels can actually be presented
  localparam int CHAN_W = $clog2(NUM_BARS) + 1;

  logic              mag_valid;
  logic              mag_ready;
  logic [CHAN_W-1:0] mag_chan;
  logic [MAG_W-1:0]  mag_data;

  modport master (output mag_valid, output mag_chan, output mag_data, input mag_ready);
  modport slave  (input mag_valid, input mag_chan, input mag_data, output mag_ready);
endinterface

// File: rtl/bar_peak_bank.sv
// Shadow/live/peak magnitude storage: write handshake into the shadow bank,
// shadow-to-live copy and peak-hold decay on each frame start.
module bar_peak_bank
  import vis_pkg::*;
#(
  parameter int NUM_BARS     = 16,
  parameter int MAG_W        = 8,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  vga_bar_renderer_if.slave           mag,
  input  logic [$clog2(NUM_BARS)-1:0] rd_idx,
  output logic [MAG_W-1:0]            live_mag,
  output logic [MAG_W-1:0]            peak_mag
);

  localparam int IDX_W  = $clog2(NUM_BARS);
  localparam int CHAN_W = $clog2(NUM_BARS) + 1;
  localparam int DCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [CHAN_W-1:0] CHAN_END  = CHAN_W'(NUM_BARS);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_FRAMES - 1);

  logic [MAG_W-1:0]  shadow [NUM_BARS];
  logic [MAG_W-1:0]  live   [NUM_BARS];
  logic [MAG_W-1:0]  peak   [NUM_BARS];
  logic [DCNT_W-1:0] dcnt;
  logic              rdy_q;
  logic              wr_en;

  function automatic logic [MAG_W-1:0] max_mag(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // the frame_start cycle is reserved for the bank swap, so writes stall there
  assign mag.mag_ready = rdy_q && !frame_start;
  assign wr_en = mag.mag_valid && mag.mag_ready && (mag.mag_chan < CHAN_END);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdy_q <= 1'b0;
      dcnt  <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
        peak[i]   <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (wr_en) shadow[mag.mag_chan[IDX_W-1:0]] <= mag.mag_data;
      if (frame_start) begin
        dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
        for (int i = 0; i < NUM_BARS; i++) begin
          live[i] <= shadow[i];
          if (shadow[i] >= peak[i])
            peak[i] <= shadow[i];
          else if (dcnt == DCNT_LAST)
            peak[i] <= max_mag(peak[i] - MAG_W'(1), shadow[i]);
        end
      end
    end
  end

  assign live_mag = live[rd_idx];
  assign peak_mag = peak[rd_idx];

endmodule

// File: rtl/vga_bar_renderer.sv
// N-channel bar-graph pixel generator: 2-stage pixel pipeline over bar_peak_bank.
// Define BAR_MIRROR_EN to mirror bars and peak markers about the screen centre line.
module vga_bar_renderer
  import vis_pkg::*;
#(
  parameter int NUM_BARS     = 16,
  parameter int MAG_W        = 8,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int GAP_PX       = 2,
  parameter int PEAK_PX      = 2,
  parameter int DECAY_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  vga_bar_renderer_if.slave mag,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);

  localparam int BAR_W = H_RES / NUM_BARS;
  localparam int IDX_W = $clog2(NUM_BARS);
  localparam int CNT_W = $clog2(NUM_BARS + 1);
  localparam int OFF_W = $clog2(BAR_W);
  localparam logic [CNT_W-1:0] BAR_END  = CNT_W'(NUM_BARS);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BAR_W - 1);
  localparam logic [OFF_W-1:0] OFF_GAP  = OFF_W'(BAR_W - GAP_PX);
  localparam logic [9:0]       Y_RES    = 10'(V_RES);
  localparam logic [9:0]       Y_RED    = 10'(V_RES / 3);
  localparam logic [9:0]       PK       = 10'(PEAK_PX);

  function automatic logic [9:0] sub_floor(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a - b : 10'd0;
  endfunction

  logic [CNT_W-1:0] idx_p1, idx_nx;
  logic [OFF_W-1:0] off_p1, off_nx;
  logic [9:0]       y_p1;
  logic             blank_p1;
  logic             vld_p1;
  logic [IDX_W-1:0] rd_idx;
  logic [MAG_W-1:0] live_mag, peak_mag;
  logic [9:0]       h_live, h_peak;
  logic             in_peak, in_body;
  rgb_t             colour;
  rgb_t             rgb_p2;

  bar_peak_bank #(
    .NUM_BARS    (NUM_BARS),
    .MAG_W       (MAG_W),
    .DECAY_FRAMES(DECAY_FRAMES)
  ) u_bank (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .mag        (mag),
    .rd_idx     (rd_idx),
    .live_mag   (live_mag),
    .peak_mag   (peak_mag)
  );

  // bar index/offset follow the previous pixel; the index stops at NUM_BARS past the last slot
  always_comb begin
    idx_nx = idx_p1;
    off_nx = off_p1;
    if (DrawX == 10'd0) begin
      idx_nx = '0;
      off_nx = '0;
    end else if (off_p1 == OFF_LAST) begin
      off_nx = '0;
      if (idx_p1 != BAR_END) idx_nx = idx_p1 + CNT_W'(1);
    end else begin
      off_nx = off_p1 + OFF_W'(1);
    end
  end

  // ---- stage 1: coordinate decode ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_p1   <= '0;
      off_p1   <= '0;
      y_p1     <= '0;
      blank_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (pix_en) begin
      idx_p1   <= idx_nx;
      off_p1   <= off_nx;
      y_p1     <= DrawY;
      blank_p1 <= blank;
      vld_p1   <= 1'b1;
    end
  end

  assign rd_idx = (idx_p1 < BAR_END) ? idx_p1[IDX_W-1:0] : '0;
  assign h_live = bar_height(MAX_MAG_W'(live_mag), MAG_W, Y_RES);
  assign h_peak = bar_height(MAX_MAG_W'(peak_mag), MAG_W, Y_RES);

`ifdef BAR_MIRROR_EN
  localparam logic [9:0] Y_MID = 10'(V_RES / 2);
  logic [9:0] hl, hp, up_hi;
  assign hl      = h_live >> 1;
  assign hp      = h_peak >> 1;
  assign up_hi   = Y_MID - hp;
  assign in_body = (y_p1 >= Y_MID - hl) && (y_p1 < Y_MID + hl);
  assign in_peak = ((y_p1 >= sub_floor(up_hi, PK)) && (y_p1 < up_hi)) ||
                   ((y_p1 >= Y_MID + hp) && (y_p1 < Y_MID + hp + PK));
`else
  logic [9:0] pk_hi;
  assign pk_hi   = Y_RES - h_peak;
  assign in_peak = (y_p1 >= sub_floor(pk_hi, PK)) && (y_p1 < pk_hi);
  assign in_body = y_p1 >= Y_RES - h_live;
`endif

  always_comb begin
    colour = BG;
    if (!vld_p1 || !blank_p1 || (idx_p1 >= BAR_END) || (off_p1 >= OFF_GAP))
      colour = BLACK;
    else if (in_peak)
      colour = WHITE;
    else if (in_body)
      colour = (y_p1 < Y_RED) ? BAR_TOP : BAR_LOW;
  end

  // ---- stage 2: colour register ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       rgb_p2 <= BLACK;
    else if (pix_en) rgb_p2 <= colour;
  end

  assign Red   = rgb_p2.r;
  assign Green = rgb_p2.g;
  assign Blue  = rgb_p2.b;

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Directed bench for vga_bar_renderer: frame swap, geometry, peak decay,
// write stall at frame start, out-of-range channels and mid-line reset.
module tb_vga_bar_renderer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pix_en;
  logic       frame_start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [7:0] Red, Green, Blue;

  int n_cmp = 0;
  int n_bad = 0;

  vga_bar_renderer_if #(.NUM_BARS(16), .MAG_W(8)) bus ();

  vga_bar_renderer #(
    .NUM_BARS(16), .MAG_W(8), .H_RES(640), .V_RES(480),
    .GAP_PX(2), .PEAK_PX(2), .DECAY_FRAMES(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pix_en     (pix_en),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .mag        (bus),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  always #10 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    n_cmp++;
    assert ({Red, Green, Blue} === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, {Red, Green, Blue}, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic strobe(input int x, input int y, input logic b);
    @(negedge Clk);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    blank  = b;
    pix_en = 1'b1;
    @(negedge Clk);
    pix_en = 1'b0;
  endtask

  // sweep a line from X=0 up to x, one more strobe, then check the colour of x
  task automatic px(input int x, input int y, input logic b, input string tag,
                    input logic [23:0] exp);
    for (int xi = 0; xi <= x; xi++) strobe(xi, y, b);
    strobe(x + 1, y, b);
    check_rgb(tag, exp);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic write(input int c, input int d);
    int n;
    n = 0;
    @(negedge Clk);
    bus.mag_valid = 1'b1;
    bus.mag_chan  = 5'(c);
    bus.mag_data  = 8'(d);
    while (!bus.mag_ready && n < 8) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    assert (n < 8)
    else begin
      n_bad++;
      $error("FAIL write_timeout: observed %0d cycles expected < 8", n);
    end
    @(negedge Clk);
    bus.mag_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; pix_en = 1'b0; frame_start = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b1;
    bus.mag_valid = 1'b0; bus.mag_chan = '0; bus.mag_data = '0;
    repeat (3) @(negedge Clk);
    check_bit("rst_ready", bus.mag_ready, 1'b0);
    check_rgb("rst_rgb", 24'h000000);
    Reset = 1'b0;
    @(negedge Clk);
    check_bit("ready_after_rst", bus.mag_ready, 1'b1);

    // empty picture: background with white markers on the bottom two rows
    px(5, 100, 1'b1, "empty_bg", 24'h000020);
    px(5, 479, 1'b1, "empty_row479", 24'hFFFFFF);
    px(5, 478, 1'b1, "empty_row478", 24'hFFFFFF);
    px(5, 477, 1'b1, "empty_row477", 24'h000020);
    px(5, 479, 1'b0, "blanked", 24'h000000);

    // chan 3 full scale: h = 478, bar top at line 2, marker on lines 0..1
    write(3, 255);
    frame();
    for (int xi = 0; xi <= 119; xi++) strobe(xi, 10, 1'b1);
    strobe(120, 10, 1'b1);
    check_rgb("lat_one_strobe", 24'h000000);
    strobe(121, 10, 1'b1);
    check_rgb("lat_two_strobes", 24'hFFFF00);
    repeat (3) @(negedge Clk);
    check_rgb("hold_between", 24'hFFFF00);
    px(125, 10, 1'b1, "ch3_y10", 24'hFFFF00);
    px(125, 1, 1'b1, "ch3_peak_y1", 24'hFFFFFF);
    px(125, 2, 1'b1, "ch3_top_y2", 24'hFFFF00);

    // chan 0 half scale: h = 240, marker on lines 238..239
    write(0, 128);
    frame();
    px(5, 240, 1'b1, "ch0_y240", 24'h00FF00);
    px(5, 239, 1'b1, "ch0_y239_peak", 24'hFFFFFF);
    px(5, 237, 1'b1, "ch0_y237", 24'h000020);
    px(38, 300, 1'b1, "ch0_gap", 24'h000000);

    // chan 5 = 200: h = 375, marker 103..104, body from 105
    write(5, 200);
    frame();
    px(203, 104, 1'b1, "ch5_peak200", 24'hFFFFFF);
    px(203, 105, 1'b1, "ch5_body", 24'hFFFF00);
    write(5, 0);
    repeat (8) frame();
    // peak decays 200 -> 198: h = 371, marker 107..108
    px(203, 108, 1'b1, "ch5_peak198_y108", 24'hFFFFFF);
    px(203, 107, 1'b1, "ch5_peak198_y107", 24'hFFFFFF);
    px(203, 109, 1'b1, "ch5_y109", 24'h000020);
    px(203, 104, 1'b1, "ch5_old_marker", 24'h000020);

    // write presented in the frame_start cycle stalls one cycle
    @(negedge Clk);
    frame_start = 1'b1;
    bus.mag_valid = 1'b1; bus.mag_chan = 5'd7; bus.mag_data = 8'd100;
    #1 check_bit("ready_in_frame_start", bus.mag_ready, 1'b0);
    @(negedge Clk);
    frame_start = 1'b0;
    #1 check_bit("ready_after_frame_start", bus.mag_ready, 1'b1);
    @(negedge Clk);
    bus.mag_valid = 1'b0;
    px(285, 400, 1'b1, "ch7_not_live", 24'h000020);
    px(285, 479, 1'b1, "ch7_peak_zero", 24'hFFFFFF);
    frame();
    // chan 7 = 100: h = 187, body from 293, marker 291..292
    px(285, 400, 1'b1, "ch7_live", 24'h00FF00);
    px(285, 292, 1'b1, "ch7_peak", 24'hFFFFFF);
    px(285, 290, 1'b1, "ch7_above", 24'h000020);

    // out-of-range channel is accepted and dropped
    @(negedge Clk);
    bus.mag_valid = 1'b1; bus.mag_chan = 5'd20; bus.mag_data = 8'd255;
    #1 check_bit("ready_chan20", bus.mag_ready, 1'b1);
    @(negedge Clk);
    bus.mag_valid = 1'b0;
    frame();
    px(165, 400, 1'b1, "chan20_bar4", 24'h000020);
    px(165, 10, 1'b1, "chan20_bar4_top", 24'h000020);

    // reset mid-line
    for (int xi = 0; xi <= 100; xi++) strobe(xi, 400, 1'b1);
    strobe(101, 400, 1'b1);
    check_rgb("pre_reset_bg", 24'h000020);
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1 check_rgb("reset_async_rgb", 24'h000000);
    check_bit("reset_ready", bus.mag_ready, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    strobe(0, 1, 1'b1);
    check_rgb("post_reset_one_strobe", 24'h000000);
    px(125, 1, 1'b1, "post_reset_ch3", 24'h000020);
    px(125, 479, 1'b1, "post_reset_ch3_marker", 24'hFFFFFF);
    px(5, 239, 1'b1, "post_reset_ch0", 24'h000020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
